counter_irq_ctrl: RTL and testbench
===================================

Name: counter_irq_ctrl

Overview:
- Downstream consumer of the three-channel counter block's counter0_out/counter1_out/counter2_out.
- Synchronises each output into the CPU clock domain and edge-detects it.
- Latches edges into sticky pending bits, masks them and raises a single CPU interrupt with channel ID and ack handshake.
- Registers are exposed on the CPU word-addressed peripheral bus.

Parameters:
- NUM_CH, 3: number of counter channels; fixed at 3 for this design, bit layouts below assume 3.
- SYNC_STAGES, 2: flops in each input synchroniser; minimum 2.

Ports:
- clk  input  1  CPU clock.
- reset  input  1  synchronous, active-low reset (reset==0 at posedge clk resets).
- counter0_out  input  1  channel 0 output; asynchronous to clk.
- counter1_out  input  1  channel 1 output; asynchronous to clk.
- counter2_out  input  1  channel 2 output; asynchronous to clk.
- bus_addr  input  2  register select: 0 STATUS, 1 MASK, 2 EDGE, 3 IRQID.
- bus_we  input  1  write strobe, one cycle.
- bus_re  input  1  read strobe, one cycle.
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data, registered.
- irq  output  1  interrupt request, registered.
- irq_id  output  2  channel of current request; valid while irq=1.
- irq_ack  input  1  CPU acknowledge, one cycle.

Behaviour:
Reset values (reset==0):
- pending=0, MASK=0, EDGE=3'b111 (rising), bus_rdata=0, irq=0, irq_id=0.
- Synchroniser flops=0; state=IDLE.
- Reset mid-request drops irq on the next edge and discards all pending.

Input path:
- Each input passes through SYNC_STAGES flops, then a history flop.
- EDGE[n]=1: event on a 0->1 transition. EDGE[n]=0: event on a 1->0 transition.
- The event sets pending[n] on the cycle after detection, giving SYNC_STAGES+1 clk latency from the first sampling edge.
- Writing EDGE clears the history compare for one cycle, so no spurious event results.

Registers:
- STATUS [2:0] pending. Read returns pending. Write is W1C: bit n cleared where bus_wdata[n]=1. Bits [31:3] read 0 except under the optional feature.
- MASK [2:0] RW; 1 enables the channel.
- EDGE [2:0] RW.
- IRQID: bit31 = any (pending & MASK); bits[1:0] = lowest-index enabled pending channel. Read-only; writes are ignored.
- bus_rdata updates the cycle after bus_re and holds its value otherwise.
- An unused address region, or bus_re and bus_we in the same cycle: the write takes effect and the read returns the pre-write value.

Interrupt FSM:
- IDLE:
  - If (pending & MASK) != 0, latch irq_id = lowest index, set irq=1, go to ASSERT.
- ASSERT (irq=1):
  - irq_ack=1: clear pending[irq_id], irq=0, go to GAP.
  - MASK[irq_id] cleared, or pending[irq_id] cleared by W1C: irq=0, go to IDLE, no ack needed.
- GAP: irq=0 for exactly one cycle, then go to IDLE.
- irq_ack in IDLE or GAP is ignored.
- irq_id does not change while in ASSERT, even if a lower-index channel becomes pending.

Simultaneous events:
- A new event on bit n in the same cycle as a W1C or ack clear of bit n: set wins, and pending[n] stays 1.
- Events on multiple channels in one cycle all set.
- A repeated event on an already-pending bit: no change (see optional feature).

Optional Feature:
COUNTER_IRQ_OVF_EN:
- Defined: STATUS[10:8] are sticky overflow bits. ovf[n] sets when an event arrives while pending[n]=1 and that same-cycle clear is not occurring. Writing bus_wdata[8+n]=1 clears ovf[n] (W1C); a simultaneous set wins. Reset value 0.
- Undefined: STATUS[10:8] read 0, writes to them are ignored, and no overflow logic is present.

Test Plan:
1. Reset, then MASK=3'b010. Drive counter1_out 0->1 → STATUS reads 0x2 after 3 clk; irq=1 with irq_id=1 one cycle later. Pulse irq_ack → irq=0 next cycle, STATUS=0, irq stays low through GAP.
2. MASK=0. Edge on all three channels → STATUS=0x7 and irq stays 0. Write MASK=0x7 → irq_id=0. Ack → irq low for GAP, then irq_id=1; ack → irq_id=2.
3. EDGE=3'b110. counter0_out 1->0 sets pending[0]; a counter0_out 0->1 pulse does not. counter2_out rising sets pending[2].
4. While irq=1 with irq_id=1, write STATUS=0x2 → irq=0 next cycle and FSM returns to IDLE. Same-cycle W1C plus new edge on ch1 → STATUS reads 0x2.
5. With MASK=0x1, assert reset==0 while irq=1 → irq=0, STATUS=0, MASK=0, EDGE=0x7 on the next cycle.
6. (COUNTER_IRQ_OVF_EN) Two ch2 edges without clearing → STATUS=0x404. Write 0x400 → STATUS=0x004. Without the macro → STATUS=0x004 and bits [10:8] always 0.

Source files
------------

// File: rtl/counter_irq_ctrl.sv
// Interrupt controller for the three counter channel outputs: synchronise, edge-detect, latch, mask, raise irq.
// Optional sticky overflow bits in STATUS[10:8] when COUNTER_IRQ_OVF_EN is defined.
module counter_irq_ctrl #(
   parameter int NUM_CH      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        counter0_out,
   input  logic        counter1_out,
   input  logic        counter2_out,
   input  logic [1:0]  bus_addr,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq,
   output logic [1:0]  irq_id,
   input  logic        irq_ack
);

   // state  | meaning
   // IDLE   | no request outstanding, waiting for an enabled pending channel
   // ASSERT | irq high for irq_id until ack, mask-off or W1C
   // GAP    | one forced low cycle after an ack
   typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_MASK   = 2'd1;
   localparam logic [1:0] ADDR_EDGE   = 2'd2;
   localparam logic [1:0] ADDR_IRQID  = 2'd3;

   state_t                              state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
   logic [NUM_CH-1:0]                   hist_q, hist_d;
   logic [NUM_CH-1:0]                   pending_q, pending_d;
   logic [NUM_CH-1:0]                   mask_q, mask_d;
   logic [NUM_CH-1:0]                   edge_q, edge_d;
   logic                                edge_blk_q, edge_blk_d;
   logic [31:0]                         rdata_q, rdata_d;
   logic                                irq_q, irq_d;
   logic [1:0]                          irq_id_q, irq_id_d;

   logic [NUM_CH-1:0] sync_out;
   logic [NUM_CH-1:0] evt;
   logic [NUM_CH-1:0] clr_w1c;
   logic [NUM_CH-1:0] clr_ack;
   logic [NUM_CH-1:0] enabled;
   logic [31:0]       status_rd;
   logic [31:0]       irqid_rd;
   logic              wr_status;
   logic              wdata_unused;

   function automatic logic [1:0] lowest_idx(input logic [NUM_CH-1:0] v);
      lowest_idx = 2'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = 2'(i);
      end
   endfunction

   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign wr_status = bus_we && (bus_addr == ADDR_STATUS);
   assign clr_w1c   = wr_status ? bus_wdata[NUM_CH-1:0] : '0;
   assign clr_ack   = (state_q == ASSERT && irq_ack) ? (NUM_CH'(1) << irq_id_q) : '0;
   assign enabled   = pending_q & mask_q;
   assign irqid_rd  = {|enabled, 29'd0, lowest_idx(enabled)};

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {counter2_out, counter1_out, counter0_out};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      hist_d = sync_out;
      // Compare is blanked for the cycle after an EDGE write so a polarity flip cannot fake an event.
      if (edge_blk_q) evt = '0;
      else            evt = (edge_q & sync_out & ~hist_q) | (~edge_q & ~sync_out & hist_q);
   end

   always_comb begin
      pending_d  = (pending_q & ~(clr_w1c | clr_ack)) | evt;
      mask_d     = mask_q;
      edge_d     = edge_q;
      edge_blk_d = 1'b0;
      if (bus_we && bus_addr == ADDR_MASK) mask_d = bus_wdata[NUM_CH-1:0];
      if (bus_we && bus_addr == ADDR_EDGE) begin
         edge_d     = bus_wdata[NUM_CH-1:0];
         edge_blk_d = 1'b1;
      end
   end

`ifdef COUNTER_IRQ_OVF_EN
   logic [NUM_CH-1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (wr_status) ovf_d = ovf_d & ~bus_wdata[8 +: NUM_CH];
      ovf_d = ovf_d | (evt & pending_q & ~(clr_w1c | clr_ack));
   end

   always_ff @(posedge clk) begin
      if (!reset) ovf_q <= '0;
      else        ovf_q <= ovf_d;
   end

   assign status_rd    = 32'(pending_q) | (32'(ovf_q) << 8);
   assign wdata_unused = ^{bus_wdata[31:8+NUM_CH], bus_wdata[7:NUM_CH]};
`else
   assign status_rd    = 32'(pending_q);
   assign wdata_unused = ^bus_wdata[31:NUM_CH];
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (bus_re) begin
         case (bus_addr)
            ADDR_STATUS: rdata_d = status_rd;
            ADDR_MASK:   rdata_d = 32'(mask_q);
            ADDR_EDGE:   rdata_d = 32'(edge_q);
            ADDR_IRQID:  rdata_d = irqid_rd;
            default:     rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      case (state_q)
         IDLE: begin
            if (|enabled) begin
               irq_id_d = lowest_idx(enabled);
               state_d  = ASSERT;
            end
         end
         ASSERT: begin
            if (irq_ack)                                         state_d = GAP;
            else if (!mask_d[irq_id_q] || clr_w1c[irq_id_q])     state_d = IDLE;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      irq_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         hist_q     <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         edge_q     <= '1;
         edge_blk_q <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         irq_id_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         edge_blk_q <= edge_blk_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         irq_id_q   <= irq_id_d;
      end
   end

   assign bus_rdata = rdata_q;
   assign irq       = irq_q;
   assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_counter_irq_ctrl.sv
// Scoreboard bench for counter_irq_ctrl: directed channel edges and bus traffic, expectations queued and checked by a monitor.
module tb_counter_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        counter0_out, counter1_out, counter2_out;
   logic [1:0]  bus_addr;
   logic        bus_we, bus_re;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        irq;
   logic [1:0]  irq_id;
   logic        irq_ack;

   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_MASK   = 2'd1;
   localparam logic [1:0] A_EDGE   = 2'd2;
   localparam logic [1:0] A_IRQID  = 2'd3;

   always #5 clk = ~clk;

   counter_irq_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .counter0_out (counter0_out),
      .counter1_out (counter1_out),
      .counter2_out (counter2_out),
      .bus_addr     (bus_addr),
      .bus_we       (bus_we),
      .bus_re       (bus_re),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .irq          (irq),
      .irq_id       (irq_id),
      .irq_ack      (irq_ack)
   );

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t rd_exp[$];
   exp_t irq_exp[$];
   exp_t mon_e;
   int   compared   = 0;
   int   mismatched = 0;
   logic rd_pend    = 1'b0;
   logic probe      = 1'b0;

   always @(posedge clk) rd_pend <= bus_re;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_exp.size() == 0) begin
            mismatched++;
            $display("FAIL read_unexpected: rdata=%h with no expectation queued", bus_rdata);
         end else begin
            mon_e = rd_exp.pop_front();
            compared++;
            if (bus_rdata !== mon_e.val) begin
               mismatched++;
               $display("FAIL %s: rdata=%h expected %h", mon_e.name, bus_rdata, mon_e.val);
            end
         end
      end
      if (probe) begin
         if (irq_exp.size() == 0) begin
            mismatched++;
            $display("FAIL irq_unexpected: irq=%b irq_id=%0d with no expectation queued", irq, irq_id);
         end else begin
            mon_e = irq_exp.pop_front();
            compared++;
            if (irq !== mon_e.val[2] || (mon_e.val[2] && irq_id !== mon_e.val[1:0])) begin
               mismatched++;
               $display("FAIL %s: irq=%b irq_id=%0d expected irq=%b irq_id=%0d",
                        mon_e.name, irq, irq_id, mon_e.val[2], mon_e.val[1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      tick();
      bus_we    = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e);
      exp_t x;
      x.name = nm;
      x.val  = e;
      rd_exp.push_back(x);
      bus_addr = a;
      bus_re   = 1'b1;
      tick();
      bus_re   = 1'b0;
   endtask

   task automatic rdwr(input string nm, input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
      exp_t x;
      x.name = nm;
      x.val  = e;
      rd_exp.push_back(x);
      bus_addr  = a;
      bus_wdata = d;
      bus_re    = 1'b1;
      bus_we    = 1'b1;
      tick();
      bus_re    = 1'b0;
      bus_we    = 1'b0;
   endtask

   task automatic chk_irq(input string nm, input logic i, input logic [1:0] id);
      exp_t x;
      x.name = nm;
      x.val  = {29'd0, i, id};
      irq_exp.push_back(x);
      probe = 1'b1;
      @(negedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   initial begin
      #200000;
      mismatched++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ovf_exp;
      reset        = 1'b0;
      counter0_out = 1'b0;
      counter1_out = 1'b0;
      counter2_out = 1'b0;
      bus_addr     = 2'd0;
      bus_we       = 1'b0;
      bus_re       = 1'b0;
      bus_wdata    = '0;
      irq_ack      = 1'b0;
      idle(3);
      reset = 1'b1;

      // reset values
      rd("rst_status", A_STATUS, 32'h0);
      rd("rst_mask",   A_MASK,   32'h0);
      rd("rst_edge",   A_EDGE,   32'h7);
      rd("rst_irqid",  A_IRQID,  32'h0);
      chk_irq("rst_irq", 1'b0, 2'd0);

      // single channel path latency and ack/GAP
      wr(A_MASK, 32'h2);
      counter1_out = 1'b1;
      tick();
      tick();
      chk_irq("t1_irq_early", 1'b0, 2'd0);
      rd("t1_status_early", A_STATUS, 32'h0);
      chk_irq("t1_irq_pre", 1'b0, 2'd0);
      rd("t1_status_set", A_STATUS, 32'h2);
      chk_irq("t1_irq_set", 1'b1, 2'd1);
      ack();
      chk_irq("t1_irq_ack", 1'b0, 2'd0);
      tick();
      chk_irq("t1_irq_gap", 1'b0, 2'd0);
      rd("t1_status_clr", A_STATUS, 32'h0);

      // all channels, masked then served lowest first
      wr(A_MASK, 32'h0);
      counter1_out = 1'b0;
      idle(4);
      counter0_out = 1'b1;
      counter1_out = 1'b1;
      counter2_out = 1'b1;
      idle(4);
      rd("t2_status_all", A_STATUS, 32'h7);
      chk_irq("t2_irq_masked", 1'b0, 2'd0);
      wr(A_MASK, 32'h7);
      rd("t2_irqid", A_IRQID, 32'h8000_0000);
      chk_irq("t2_irq_ch0", 1'b1, 2'd0);
      ack();
      chk_irq("t2_gap_a", 1'b0, 2'd0);
      tick();
      chk_irq("t2_gap_b", 1'b0, 2'd0);
      tick();
      chk_irq("t2_irq_ch1", 1'b1, 2'd1);
      ack();
      tick();
      tick();
      chk_irq("t2_irq_ch2", 1'b1, 2'd2);
      ack();
      rd("t2_status_clr", A_STATUS, 32'h0);
      chk_irq("t2_irq_done", 1'b0, 2'd0);

      // edge polarity selection
      wr(A_MASK, 32'h0);
      wr(A_EDGE, 32'h6);
      rd("t3_edge", A_EDGE, 32'h6);
      counter2_out = 1'b0;
      idle(4);
      counter0_out = 1'b0;
      idle(4);
      rd("t3_fall_ch0", A_STATUS, 32'h1);
      wr(A_STATUS, 32'h1);
      counter0_out = 1'b1;
      idle(4);
      rd("t3_rise_ch0_ignored", A_STATUS, 32'h0);
      counter2_out = 1'b1;
      idle(4);
      rd("t3_rise_ch2", A_STATUS, 32'h4);
      wr(A_STATUS, 32'h4);

      // W1C while asserted, then W1C colliding with a new event
      counter1_out = 1'b0;
      idle(4);
      wr(A_MASK, 32'h2);
      counter1_out = 1'b1;
      idle(4);
      chk_irq("t4_irq_ch1", 1'b1, 2'd1);
      wr(A_STATUS, 32'h2);
      chk_irq("t4_irq_w1c", 1'b0, 2'd0);
      tick();
      chk_irq("t4_irq_idle", 1'b0, 2'd0);
      rd("t4_status_w1c", A_STATUS, 32'h0);
      wr(A_MASK, 32'h0);
      counter1_out = 1'b0;
      idle(4);
      counter1_out = 1'b1;
      idle(4);
      counter1_out = 1'b0;
      idle(4);
      counter1_out = 1'b1;
      tick();
      tick();
      wr(A_STATUS, 32'h2);
      rd("t4_set_wins", A_STATUS, 32'h2);
      wr(A_STATUS, 32'h2);
      rd("t4_status_clr", A_STATUS, 32'h0);

      // reset in the middle of a request
      counter1_out = 1'b0;
      counter2_out = 1'b0;
      wr(A_MASK, 32'h1);
      counter0_out = 1'b0;
      idle(4);
      chk_irq("t5_irq_ch0", 1'b1, 2'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_irq("t5_irq_rst", 1'b0, 2'd0);
      rd("t5_status", A_STATUS, 32'h0);
      rd("t5_mask",   A_MASK,   32'h0);
      rd("t5_edge",   A_EDGE,   32'h7);
      rd("t5_irqid",  A_IRQID,  32'h0);

      // repeated event on a pending bit
`ifdef COUNTER_IRQ_OVF_EN
      ovf_exp = 32'h404;
`else
      ovf_exp = 32'h004;
`endif
      counter2_out = 1'b1;
      idle(4);
      counter2_out = 1'b0;
      idle(4);
      counter2_out = 1'b1;
      idle(4);
      rd("t6_repeat", A_STATUS, ovf_exp);
      wr(A_STATUS, 32'h400);
      rd("t6_ovf_clr", A_STATUS, 32'h004);
      wr(A_STATUS, 32'h4);
      rd("t6_status_clr", A_STATUS, 32'h0);

      // bus corner cases
      rdwr("rw_same_cycle", A_MASK, 32'h5, 32'h0);
      rd("rw_mask_after", A_MASK, 32'h5);
      wr(A_IRQID, 32'hFFFF_FFFF);
      rd("irqid_ro", A_IRQID, 32'h0);
      wr(A_MASK, 32'hFFFF_FFF8);
      rd("mask_upper", A_MASK, 32'h0);

      idle(3);
      if (rd_exp.size() != 0 || irq_exp.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d reads and %0d irq checks left, expected 0 and 0", rd_exp.size(), irq_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
